// File: rtl/acc_requant_drain.sv
// acc_requant_drain: snapshots the MAC accumulator array on start, clears the
// MACs, then requantizes each accumulator (multiply, round, shift, zero point,
// optional ReLU, saturate) through a 2-stage pipeline and streams the results
// out over valid/ready.
module acc_requant_drain #(
   parameter  int N_MAC   = 8,
   parameter  int ACC_W   = 32,
   parameter  int MULT_W  = 16,
   parameter  int SHIFT_W = 5,
   parameter  int OUT_W   = 8,
   localparam int IDX_W   = (N_MAC > 1) ? $clog2(N_MAC) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [N_MAC*ACC_W-1:0]   acc_in,
   input  logic [MULT_W-1:0]        scale_mult,
   input  logic [SHIFT_W-1:0]       shift,
   input  logic signed [OUT_W-1:0]  zero_point,
   input  logic                     relu_en,
   output logic                     mac_clr,
   output logic                     busy,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [OUT_W-1:0]  out_data,
   output logic [IDX_W-1:0]         out_idx,
   output logic                     out_last,
   output logic                     done
);

   // Product is wide enough that snap * scale can never wrap; the rounded value
   // needs one more bit for the bias add, and the zero-point sum one more again.
   localparam int P_W   = ACC_W + MULT_W + 1;
   localparam int R_W   = P_W + 1;
   localparam int V_W   = P_W + 2;
   localparam int CNT_W = $clog2(N_MAC + 1);

   localparam logic [CNT_W-1:0]      N_CNT    = CNT_W'(N_MAC);
   localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(N_MAC - 1);
   localparam logic signed [V_W-1:0] OMAX     = V_W'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [V_W-1:0] OMIN     = V_W'(-(2 ** (OUT_W - 1)));

   typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

   state_t                    state_q, state_d;
   logic signed [ACC_W-1:0]   snap_q [N_MAC];
   logic [MULT_W-1:0]         scale_q;
   logic [SHIFT_W-1:0]        shift_q;
   logic signed [OUT_W-1:0]   zp_q;
   logic                      relu_q;
   logic [CNT_W-1:0]          cnt_q;

   logic signed [P_W-1:0]     snap_x, scale_x, prod_d;
   logic signed [P_W-1:0]     prod_p1;
   logic [IDX_W-1:0]          idx_p1;
   logic                      last_p1, vld_p1;

   logic signed [OUT_W-1:0]   data_p2;
   logic [IDX_W-1:0]          idx_p2;
   logic                      last_p2, vld_p2;
   logic                      done_q;

   logic                      accept, issue, adv, beat_last;

   // Round half toward +inf while shifting right by sh (sh = 0 passes through).
   function automatic logic signed [R_W-1:0] round_shift(input logic signed [P_W-1:0] p,
                                                         input logic [SHIFT_W-1:0] sh);
      logic signed [R_W-1:0] pe, bias;
      pe   = R_W'(p);
      bias = R_W'(1) << (sh - 1'b1);
      if (sh == '0) return pe;
      return (pe + bias) >>> sh;
   endfunction

   // Clamp to the signed OUT_W range.
   function automatic logic signed [OUT_W-1:0] sat(input logic signed [V_W-1:0] v);
      if (v > OMAX) return {1'b0, {(OUT_W-1){1'b1}}};
      if (v < OMIN) return {1'b1, {(OUT_W-1){1'b0}}};
      return v[OUT_W-1:0];
   endfunction

   // Rounded/shifted value plus zero point, ReLU floor at the zero point, saturate.
   function automatic logic signed [OUT_W-1:0] requant(input logic signed [P_W-1:0] p,
                                                      input logic [SHIFT_W-1:0] sh,
                                                      input logic signed [OUT_W-1:0] zp,
                                                      input logic relu);
      logic signed [V_W-1:0] v, zpe;
      zpe = V_W'(zp);
      v   = V_W'(round_shift(p, sh)) + zpe;
      if (relu && (v < zpe)) v = zpe;
      return sat(v);
   endfunction

   assign accept    = (state_q == IDLE) && start;
   assign mac_clr   = accept && !rst;
   assign issue     = (state_q == DRAIN) && (cnt_q < N_CNT);
   // A visible beat that is not taken freezes every stage and the issue counter.
   assign adv       = !(vld_p2 && !out_ready);
   assign beat_last = vld_p2 && out_ready && last_p2;

   assign busy      = (state_q == DRAIN);
   assign out_valid = vld_p2;
   assign out_data  = data_p2;
   assign out_idx   = idx_p2;
   assign out_last  = last_p2;
   assign done      = done_q;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state: drain on start, return once the final beat is taken.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)     state_d = DRAIN;
         DRAIN:   if (beat_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Snapshot the accumulators and the requant configuration on acceptance.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < N_MAC; i++) snap_q[i] <= acc_in[i*ACC_W +: ACC_W];
         scale_q <= scale_mult;
         shift_q <= shift;
         zp_q    <= zero_point;
         relu_q  <= relu_en;
      end
   end

   // Issue counter walks the snapshot in order, one element per advancing cycle.
   always_ff @(posedge clk) begin
      if (rst)                cnt_q <= '0;
      else if (accept)        cnt_q <= '0;
      else if (issue && adv)  cnt_q <= cnt_q + 1'b1;
   end

   // Full-width signed product of the issued element and the unsigned scale.
   always_comb begin
      snap_x = P_W'(snap_q[cnt_q[IDX_W-1:0]]);
      scale_x = P_W'(scale_q);
      prod_d = snap_x * scale_x;
   end

   // ---- stage 1: multiply ----
   always_ff @(posedge clk) begin
      if (rst)      vld_p1 <= 1'b0;
      else if (adv) vld_p1 <= issue;
   end

   // Stage 1 data registers (no reset needed, qualified by vld_p1).
   always_ff @(posedge clk) begin
      if (adv && issue) begin
         prod_p1 <= prod_d;
         idx_p1  <= cnt_q[IDX_W-1:0];
         last_p1 <= (cnt_q == LAST_CNT);
      end
   end

   // ---- stage 2: round, shift, zero point, ReLU, saturate -> output ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p2  <= 1'b0;
         last_p2 <= 1'b0;
         data_p2 <= '0;
         idx_p2  <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= beat_last;
         if (adv) begin
            vld_p2  <= vld_p1;
            last_p2 <= vld_p1 && last_p1;
            if (vld_p1) begin
               data_p2 <= requant(prod_p1, shift_q, zp_q, relu_q);
               idx_p2  <= idx_p1;
            end
         end
      end
   end

endmodule
